// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider producing {remainder, quotient}.
// Designed to sit beside the single-cycle ALU; the controller stalls on busy and takes out on done.
module seq_divider #(
  parameter int unsigned WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   in1,
  input  logic [WIDTH-1:0]   in2,
  output logic               busy,
  output logic               done,
  output logic               div_by_zero,
  output logic [2*WIDTH-1:0] out
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StCalc, StFinish} state_e;

  state_e             state_q, state_d;
  logic [CntW-1:0]    count_q, count_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   dsr_q, dsr_d;
  logic               zero_q, zero_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               dbz_q, dbz_d;
  logic [2*WIDTH-1:0] out_q, out_d;

  logic [WIDTH:0]     rem_sh;
  logic [WIDTH:0]     trial;

  // rem < divisor, so the shifted remainder needs one extra bit; trial's MSB is the borrow.
  assign rem_sh = {rem_q, quo_q[WIDTH-1]};
  assign trial  = rem_sh - {1'b0, dsr_q};

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dsr_d   = dsr_q;
    zero_d  = zero_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    dbz_d   = dbz_q;
    out_d   = out_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          quo_d   = in1;
          rem_d   = '0;
          dsr_d   = in2;
          count_d = '0;
          zero_d  = (in2 == '0);
          busy_d  = 1'b1;
          state_d = (in2 == '0) ? StFinish : StCalc;
        end
      end
      StCalc: begin
        count_d = count_q + 1'b1;
        if (!trial[WIDTH]) begin
          rem_d = trial[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = rem_sh[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
        if (count_q == LastCnt) state_d = StFinish;
      end
      StFinish: begin
        // On divide-by-zero the quotient register still holds the untouched dividend.
        out_d   = zero_q ? {quo_q, {WIDTH{1'b1}}} : {rem_q, quo_q};
        dbz_d   = zero_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      count_q <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dsr_q   <= '0;
      zero_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dsr_q   <= dsr_d;
      zero_q  <= zero_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
      out_q   <= out_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign out         = out_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed and swept checks of seq_divider: latency, busy window, results, divide-by-zero,
// ignored start while busy, back-to-back issue and mid-operation reset.
module tb_seq_divider;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] in1, in2;
  logic        busy, done, div_by_zero;
  logic [31:0] out;

  int n_tot = 0;
  int n_bad = 0;
  logic [31:0] last_out = '0;
  logic        last_dbz = 1'b0;

  seq_divider #(.WIDTH(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .in1        (in1),
    .in2        (in2),
    .busy       (busy),
    .done       (done),
    .div_by_zero(div_by_zero),
    .out        (out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Called #1 after the accepting edge; waits for done, optionally poking start at poke_at.
  task automatic wait_done(input int poke_at, output int lat, output int busyc, output bit got);
    lat = 0;
    busyc = 0;
    got = 0;
    while (!got && lat < 40) begin
      if (busy) busyc++;
      if (done) begin
        got = 1;
      end else begin
        if (lat == poke_at) begin
          start = 1'b1;
          in1 = 16'd200;
          in2 = 16'd3;
        end else begin
          start = 1'b0;
        end
        @(posedge clk); #1;
        lat++;
      end
    end
    start = 1'b0;
  endtask

  task automatic accept(input logic [15:0] a, input logic [15:0] b, input string tag);
    @(negedge clk);
    start = 1'b1;
    in1 = a;
    in2 = b;
    @(posedge clk); #1;
    start = 1'b0;
    in1 = 16'($urandom);
    in2 = 16'($urandom);
    check({tag, " busy@accept"}, 32'(busy), 32'd1);
    check({tag, " out held"}, out, last_out);
    check({tag, " dbz held"}, 32'(div_by_zero), 32'(last_dbz));
  endtask

  task automatic finish_checks(input string tag, input int lat, input int busyc, input bit got,
                               input logic [31:0] eo, input logic ed, input int elat);
    check({tag, " got done"}, 32'(got), 32'd1);
    check({tag, " latency"}, 32'(lat), 32'(elat));
    check({tag, " busy cycles"}, 32'(busyc), 32'(elat));
    check({tag, " out"}, out, eo);
    check({tag, " dbz"}, 32'(div_by_zero), 32'(ed));
    check({tag, " busy@done"}, 32'(busy), 32'd0);
    last_out = eo;
    last_dbz = ed;
  endtask

  task automatic do_div(input logic [15:0] a, input logic [15:0] b, input logic [31:0] eo,
                        input logic ed, input int elat, input string tag);
    int lat, busyc;
    bit got;
    accept(a, b, tag);
    wait_done(-1, lat, busyc, got);
    finish_checks(tag, lat, busyc, got, eo, ed, elat);
    @(posedge clk); #1;
    check({tag, " done pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    int lat, busyc, cnt;
    bit got;
    logic [15:0] a, b;

    rst_n = 1'b0;
    start = 1'b0;
    in1 = '0;
    in2 = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst dbz", 32'(div_by_zero), 32'd0);
    check("rst out", out, 32'h0000_0000);

    do_div(16'd100, 16'd7, 32'h0002_000E, 1'b0, 17, "100/7");
    do_div(16'hFFFF, 16'd1, 32'h0000_FFFF, 1'b0, 17, "ffff/1");
    do_div(16'd3, 16'd10, 32'h0003_0000, 1'b0, 17, "3/10");
    do_div(16'hFFFF, 16'hFFFF, 32'h0000_0001, 1'b0, 17, "ffff/ffff");
    do_div(16'd5, 16'd0, 32'h0005_FFFF, 1'b1, 1, "5/0");
    do_div(16'd100, 16'd7, 32'h0002_000E, 1'b0, 17, "100/7 after dbz");

    // start while busy is ignored; start in the done cycle is accepted
    accept(16'd100, 16'd7, "ign");
    wait_done(5, lat, busyc, got);
    finish_checks("ign", lat, busyc, got, 32'h0002_000E, 1'b0, 17);
    start = 1'b1;
    in1 = 16'd1000;
    in2 = 16'd10;
    @(posedge clk); #1;
    start = 1'b0;
    in1 = 16'hDEAD;
    in2 = 16'h0;
    check("b2b busy@accept", 32'(busy), 32'd1);
    check("b2b done low", 32'(done), 32'd0);
    wait_done(-1, lat, busyc, got);
    finish_checks("b2b", lat, busyc, got, 32'h0000_0064, 1'b0, 17);

    // reset during iteration 8 aborts the division
    accept(16'd100, 16'd7, "abort");
    repeat (8) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("abort busy", 32'(busy), 32'd0);
    check("abort done", 32'(done), 32'd0);
    check("abort dbz", 32'(div_by_zero), 32'd0);
    check("abort out", out, 32'h0000_0000);
    cnt = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done) cnt++;
    end
    check("abort no done", 32'(cnt), 32'd0);
    last_out = '0;
    last_dbz = 1'b0;
    do_div(16'd100, 16'd7, 32'h0002_000E, 1'b0, 17, "100/7 after abort");

    for (int i = 0; i < 1000; i++) begin
      a = 16'($urandom);
      b = (i % 4 == 0) ? 16'($urandom_range(1, 15)) : 16'($urandom_range(1, 65535));
      do_div(a, b, {a % b, a / b}, 1'b0, 17, "sweep");
    end

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
